// File: rtl/decode_stage.sv
// ID/EX pipeline register: decodes one RISC-V instruction into an execute control bundle,
// with ready/valid on both sides, flush, and automatic load-use bubble insertion.
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic            out_muldiv,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal,
  output logic [2:0]      out_mem_size,
  output logic            out_op_b_reg,
  output logic [1:0]      out_op_a_sel,
  output logic [1:0]      out_wb_sel
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_e;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'b00,
    OPA_PC   = 2'b01,
    OPA_ZERO = 2'b10
  } opa_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_e;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // alt selects SUB/SRA on funct3 000/101
  function automatic logic [3:0] alu_of_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] r;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0] imm_d;
  logic [3:0]      alu_d;
  logic            muldiv_d, rw_d, mr_d, mw_d, br_d, jmp_d, ill_d, opb_d;
  logic [2:0]      msz_d;
  logic [1:0]      opa_d, wb_d;

  always_comb begin
    rs1_d    = '0;
    rs2_d    = '0;
    rd_d     = '0;
    imm_d    = '0;
    alu_d    = ALU_ADD;
    muldiv_d = 1'b0;
    rw_d     = 1'b0;
    mr_d     = 1'b0;
    mw_d     = 1'b0;
    br_d     = 1'b0;
    jmp_d    = 1'b0;
    ill_d    = 1'b0;
    opb_d    = 1'b0;
    msz_d    = '0;
    opa_d    = OPA_RS1;
    wb_d     = WB_ALU;
    case (opcode)
      OPC_OP: begin
        rs1_d = in_instr[19:15];
        rs2_d = in_instr[24:20];
        rd_d  = in_instr[11:7];
        opb_d = 1'b1;
        rw_d  = 1'b1;
        case (funct7)
          7'b0000000: alu_d = alu_of_f3(funct3, 1'b0);
          7'b0100000: begin
            if (funct3 == 3'b000 || funct3 == 3'b101) alu_d = alu_of_f3(funct3, 1'b1);
            else                                      ill_d = 1'b1;
          end
          7'b0000001: begin
            if (ENABLE_M) begin
              muldiv_d = 1'b1;
              alu_d    = {1'b0, funct3};
            end else begin
              ill_d = 1'b1;
            end
          end
          default: ill_d = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        rs1_d = in_instr[19:15];
        rd_d  = in_instr[11:7];
        rw_d  = 1'b1;
        alu_d = alu_of_f3(funct3, 1'b0);
        imm_d = sext({{20{in_instr[31]}}, in_instr[31:20]});
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shifts carry a zero-extended shamt; the bits above it must be a valid funct pattern.
          alu_d = alu_of_f3(funct3, in_instr[30]);
          imm_d = '0;
          if (XLEN == 64) begin
            imm_d[5:0] = in_instr[25:20];
            if (!(in_instr[31:26] == 6'b000000 ||
                  (funct3 == 3'b101 && in_instr[31:26] == 6'b010000))) ill_d = 1'b1;
          end else begin
            imm_d[4:0] = in_instr[24:20];
            if (!(funct7 == 7'b0000000 ||
                  (funct3 == 3'b101 && funct7 == 7'b0100000))) ill_d = 1'b1;
          end
        end
      end
      OPC_LOAD: begin
        rs1_d = in_instr[19:15];
        rd_d  = in_instr[11:7];
        imm_d = sext({{20{in_instr[31]}}, in_instr[31:20]});
        rw_d  = 1'b1;
        mr_d  = 1'b1;
        wb_d  = WB_LOAD;
        msz_d = funct3;
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ill_d = 1'b0;
          3'b011, 3'b110:                         ill_d = (XLEN != 64);
          default:                                ill_d = 1'b1;
        endcase
      end
      OPC_STORE: begin
        rs1_d = in_instr[19:15];
        rs2_d = in_instr[24:20];
        imm_d = sext({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
        mw_d  = 1'b1;
        msz_d = funct3;
        case (funct3)
          3'b000, 3'b001, 3'b010: ill_d = 1'b0;
          3'b011:                 ill_d = (XLEN != 64);
          default:                ill_d = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        rs1_d = in_instr[19:15];
        rs2_d = in_instr[24:20];
        imm_d = sext({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0});
        br_d  = 1'b1;
        opa_d = OPA_PC;
        ill_d = (funct3 == 3'b010 || funct3 == 3'b011);
      end
      OPC_JAL: begin
        rd_d  = in_instr[11:7];
        imm_d = sext({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0});
        jmp_d = 1'b1;
        rw_d  = 1'b1;
        opa_d = OPA_PC;
        wb_d  = WB_PC4;
      end
      OPC_JALR: begin
        rs1_d = in_instr[19:15];
        rd_d  = in_instr[11:7];
        imm_d = sext({{20{in_instr[31]}}, in_instr[31:20]});
        jmp_d = 1'b1;
        rw_d  = 1'b1;
        wb_d  = WB_PC4;
        ill_d = (funct3 != 3'b000);
      end
      OPC_LUI: begin
        rd_d  = in_instr[11:7];
        imm_d = sext({in_instr[31:12], 12'h000});
        rw_d  = 1'b1;
        opa_d = OPA_ZERO;
      end
      OPC_AUIPC: begin
        rd_d  = in_instr[11:7];
        imm_d = sext({in_instr[31:12], 12'h000});
        rw_d  = 1'b1;
        opa_d = OPA_PC;
      end
      default: ill_d = 1'b1;
    endcase
    if (ill_d) begin
      rw_d  = 1'b0;
      mr_d  = 1'b0;
      mw_d  = 1'b0;
      br_d  = 1'b0;
      jmp_d = 1'b0;
    end
  end

  logic            valid_q;
  logic [XLEN-1:0] pc_q, imm_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [3:0]      alu_q;
  logic            muldiv_q, rw_q, mr_q, mw_q, br_q, jmp_q, ill_q, opb_q;
  logic [2:0]      msz_q;
  logic [1:0]      opa_q, wb_q;
  logic            hazard;

  // Unused source fields decode to x0, so they can never match a nonzero load rd.
  assign hazard   = valid_q && mr_q && (rd_q != 5'd0) && ((rs1_d == rd_q) || (rs2_d == rd_q));
  assign in_ready = !reset && (flush || ((!valid_q || ex_ready) && !hazard));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      imm_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      alu_q    <= '0;
      muldiv_q <= 1'b0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      br_q     <= 1'b0;
      jmp_q    <= 1'b0;
      ill_q    <= 1'b0;
      opb_q    <= 1'b0;
      msz_q    <= '0;
      opa_q    <= '0;
      wb_q     <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q  <= 1'b1;
      pc_q     <= in_pc;
      imm_q    <= imm_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      alu_q    <= alu_d;
      muldiv_q <= muldiv_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      br_q     <= br_d;
      jmp_q    <= jmp_d;
      ill_q    <= ill_d;
      opb_q    <= opb_d;
      msz_q    <= msz_d;
      opa_q    <= opa_d;
      wb_q     <= wb_d;
    end else if (ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_rd        = rd_q;
  assign out_imm       = imm_q;
  assign out_alu_op    = alu_q;
  assign out_muldiv    = muldiv_q;
  assign out_reg_write = rw_q;
  assign out_mem_read  = mr_q;
  assign out_mem_write = mw_q;
  assign out_branch    = br_q;
  assign out_jump      = jmp_q;
  assign out_illegal   = ill_q;
  assign out_mem_size  = msz_q;
  assign out_op_b_reg  = opb_q;
  assign out_op_a_sel  = opa_q;
  assign out_wb_sel    = wb_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M decode off/on) checked every cycle against a
// behavioural model, plus hand-computed expectations on directed instruction sequences.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        muldiv, rw, mr, mw, br, jmp, ill;
    logic [2:0]  msz;
    logic        opb;
    logic [1:0]  opa, wb;
  } bundle_t;

  localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_ADDI  = 32'hFFF18213; // addi x4,x3,-1
  localparam logic [31:0] I_LW    = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD6  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_LW0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD60 = 32'h00200333; // add  x6,x0,x2
  localparam logic [31:0] I_SUB   = 32'h402081B3; // sub  x3,x1,x2
  localparam logic [31:0] I_MUL   = 32'h02208033; // mul  x0,x1,x2
  localparam logic [31:0] I_BADSH = 32'h40001013; // slli with funct7=0100000
  localparam logic [31:0] I_JAL   = 32'hFFDFF0EF; // jal  x1,-4
  localparam logic [31:0] I_LUI   = 32'h123453B7; // lui  x7,0x12345
  localparam logic [31:0] I_SW    = 32'h0020A423; // sw   x2,8(x1)
  localparam logic [31:0] I_BEQ   = 32'hFE208CE3; // beq  x1,x2,-8
  localparam logic [31:0] I_SRAI  = 32'h4030D213; // srai x4,x1,3
  localparam logic [31:0] I_JALR  = 32'h004100E7; // jalr x1,4(x2)
  localparam logic [31:0] I_AUIPC = 32'h00001297; // auipc x5,1

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, ex_ready;
  logic [31:0] in_instr, in_pc;

  logic        o_ready[2], o_valid[2], o_muldiv[2], o_rw[2], o_mr[2], o_mw[2];
  logic        o_br[2], o_jmp[2], o_ill[2], o_opb[2];
  logic [31:0] o_pc[2], o_imm[2];
  logic [4:0]  o_rs1[2], o_rs2[2], o_rd[2];
  logic [3:0]  o_alu[2];
  logic [2:0]  o_msz[2];
  logic [1:0]  o_opa[2], o_wb[2];

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_ready[0]),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_ready(ex_ready),
    .out_valid(o_valid[0]), .out_pc(o_pc[0]), .out_rs1(o_rs1[0]), .out_rs2(o_rs2[0]),
    .out_rd(o_rd[0]), .out_imm(o_imm[0]), .out_alu_op(o_alu[0]), .out_muldiv(o_muldiv[0]),
    .out_reg_write(o_rw[0]), .out_mem_read(o_mr[0]), .out_mem_write(o_mw[0]),
    .out_branch(o_br[0]), .out_jump(o_jmp[0]), .out_illegal(o_ill[0]),
    .out_mem_size(o_msz[0]), .out_op_b_reg(o_opb[0]), .out_op_a_sel(o_opa[0]),
    .out_wb_sel(o_wb[0])
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_ready[1]),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_ready(ex_ready),
    .out_valid(o_valid[1]), .out_pc(o_pc[1]), .out_rs1(o_rs1[1]), .out_rs2(o_rs2[1]),
    .out_rd(o_rd[1]), .out_imm(o_imm[1]), .out_alu_op(o_alu[1]), .out_muldiv(o_muldiv[1]),
    .out_reg_write(o_rw[1]), .out_mem_read(o_mr[1]), .out_mem_write(o_mw[1]),
    .out_branch(o_br[1]), .out_jump(o_jmp[1]), .out_illegal(o_ill[1]),
    .out_mem_size(o_msz[1]), .out_op_b_reg(o_opb[1]), .out_op_a_sel(o_opa[1]),
    .out_wb_sel(o_wb[1])
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          done     = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ALU code per funct3 for the non-alternate operations
  logic [3:0] alu_tab [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};

  function automatic bundle_t dec(input logic [31:0] ins, input logic [31:0] pc, input bit em);
    bundle_t    b;
    bit         ok;
    int         v;
    logic [2:0] f3;
    logic [6:0] f7;
    b  = '0;
    b.pc = pc;
    ok = 1'b1;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      7'h33: begin
        b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7]; b.opb = 1'b1; b.rw = 1'b1;
        if (f7 == 7'h01) begin
          ok = em;
          if (em) begin b.muldiv = 1'b1; b.alu = {1'b0, f3}; end
        end else if (f7 == 7'h00) b.alu = alu_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) b.alu = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) b.alu = 4'd7;
        else ok = 1'b0;
      end
      7'h13: begin
        b.rs1 = ins[19:15]; b.rd = ins[11:7]; b.rw = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          b.imm = {27'd0, ins[24:20]};
          ok    = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
          b.alu = (f3 == 3'd1) ? 4'd5 : (ins[30] ? 4'd7 : 4'd6);
        end else begin
          v = int'($signed(ins[31:20]));
          b.imm = v;
          b.alu = alu_tab[f3];
        end
      end
      7'h03: begin
        b.rs1 = ins[19:15]; b.rd = ins[11:7]; b.mr = 1'b1; b.rw = 1'b1; b.wb = 2'd1; b.msz = f3;
        v = int'($signed(ins[31:20]));
        b.imm = v;
        ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      end
      7'h23: begin
        b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.mw = 1'b1; b.msz = f3;
        v = int'($signed({ins[31:25], ins[11:7]}));
        b.imm = v;
        ok = (f3 <= 3'd2);
      end
      7'h63: begin
        b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.br = 1'b1; b.opa = 2'd1;
        v = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
        b.imm = v;
        ok = (f3 != 3'd2 && f3 != 3'd3);
      end
      7'h6F: begin
        b.rd = ins[11:7]; b.jmp = 1'b1; b.rw = 1'b1; b.opa = 2'd1; b.wb = 2'd2;
        v = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
        b.imm = v;
      end
      7'h67: begin
        b.rs1 = ins[19:15]; b.rd = ins[11:7]; b.jmp = 1'b1; b.rw = 1'b1; b.wb = 2'd2;
        v = int'($signed(ins[31:20]));
        b.imm = v;
        ok = (f3 == 3'd0);
      end
      7'h37: begin b.rd = ins[11:7]; b.rw = 1'b1; b.opa = 2'd2; b.imm = {ins[31:12], 12'h000}; end
      7'h17: begin b.rd = ins[11:7]; b.rw = 1'b1; b.opa = 2'd1; b.imm = {ins[31:12], 12'h000}; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      b.ill = 1'b1; b.rw = 1'b0; b.mr = 1'b0; b.mw = 1'b0; b.br = 1'b0; b.jmp = 1'b0;
    end
    return b;
  endfunction

  bundle_t mb[2];
  bit      mv[2];

  function automatic bit m_hazard(input int k);
    bundle_t d;
    d = dec(in_instr, in_pc, k == 1);
    return mv[k] && mb[k].mr && mb[k].rd != 5'd0 && (d.rs1 == mb[k].rd || d.rs2 == mb[k].rd);
  endfunction

  function automatic bit m_ready(input int k);
    return !reset && (flush || ((!mv[k] || ex_ready) && !m_hazard(k)));
  endfunction

  task automatic cmp_all(input int k);
    string p;
    p = $sformatf("dut%0d.", k);
    chk({p, "in_ready"},  o_ready[k],  m_ready(k));
    chk({p, "out_valid"}, o_valid[k],  mv[k]);
    chk({p, "out_pc"},    o_pc[k],     mb[k].pc);
    chk({p, "out_rs1"},   o_rs1[k],    mb[k].rs1);
    chk({p, "out_rs2"},   o_rs2[k],    mb[k].rs2);
    chk({p, "out_rd"},    o_rd[k],     mb[k].rd);
    chk({p, "out_imm"},   o_imm[k],    mb[k].imm);
    chk({p, "alu_op"},    o_alu[k],    mb[k].alu);
    chk({p, "muldiv"},    o_muldiv[k], mb[k].muldiv);
    chk({p, "reg_write"}, o_rw[k],     mb[k].rw);
    chk({p, "mem_read"},  o_mr[k],     mb[k].mr);
    chk({p, "mem_write"}, o_mw[k],     mb[k].mw);
    chk({p, "branch"},    o_br[k],     mb[k].br);
    chk({p, "jump"},      o_jmp[k],    mb[k].jmp);
    chk({p, "illegal"},   o_ill[k],    mb[k].ill);
    chk({p, "mem_size"},  o_msz[k],    mb[k].msz);
    chk({p, "op_b_reg"},  o_opb[k],    mb[k].opb);
    chk({p, "op_a_sel"},  o_opa[k],    mb[k].opa);
    chk({p, "wb_sel"},    o_wb[k],     mb[k].wb);
  endtask

  initial begin
    mb[0] = '0; mb[1] = '0; mv[0] = 1'b0; mv[1] = 1'b0;
    forever begin
      bit acc[2];
      @(posedge clk);
      for (int k = 0; k < 2; k++) acc[k] = in_valid && m_ready(k);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          mv[k] = 1'b0; mb[k] = '0;
        end else if (flush) begin
          mv[k] = 1'b0;
        end else if (acc[k]) begin
          mv[k] = 1'b1; mb[k] = dec(in_instr, in_pc, k == 1);
        end else if (ex_ready) begin
          mv[k] = 1'b0;
        end
      end
      #2;
      if (!done) for (int k = 0; k < 2; k++) cmp_all(k);
    end
  end

  task automatic apply(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit exr, input bit fl);
    in_valid = v; in_instr = ins; in_pc = pc; ex_ready = exr; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                     input bit exr, input bit fl);
    apply(v, ins, pc, exr, fl);
    tick();
  endtask

  logic [31:0] prog [16] = '{I_ADD, I_ADDI, I_LW, I_ADD6, I_LW0, I_ADD60, I_SUB, I_MUL,
                             I_BADSH, I_JAL, I_LUI, I_SW, I_BEQ, I_SRAI, I_JALR, I_AUIPC};

  initial begin
    bundle_t pin;
    reset = 1'b1;
    in_valid = 1'b1; in_instr = $urandom; in_pc = $urandom; ex_ready = 1'b1; flush = 1'b0;

    // model pins
    pin = dec(I_JAL, 32'h100, 1'b0);
    chk("model.jal_imm", pin.imm, 32'hFFFFFFFC);
    pin = dec(I_BEQ, 32'h0, 1'b0);
    chk("model.beq_imm", pin.imm, 32'hFFFFFFF8);
    pin = dec(I_SW, 32'h0, 1'b0);
    chk("model.sw_imm", pin.imm, 32'h8);

    repeat (3) tick();
    #1;
    chk("rst.valid0", o_valid[0], 0);
    chk("rst.ill0",   o_ill[0],   0);
    chk("rst.pc1",    o_pc[1],    0);
    chk("rst.ready0", o_ready[0], 0);
    chk("rst.ready1", o_ready[1], 0);
    reset = 1'b0;
    apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("rel.ready0", o_ready[0], 1);
    tick();

    // back-to-back stream
    cyc(1'b1, I_ADD, 32'h10, 1'b1, 1'b0);
    chk("add.valid", o_valid[0], 1);
    chk("add.alu",   o_alu[0],   0);
    chk("add.opb",   o_opb[0],   1);
    chk("add.rd",    o_rd[0],    3);
    cyc(1'b1, I_ADDI, 32'h14, 1'b1, 1'b0);
    chk("addi.valid", o_valid[0], 1);
    chk("addi.imm",   o_imm[0],   32'hFFFFFFFF);
    chk("addi.opb",   o_opb[0],   0);
    chk("addi.pc",    o_pc[0],    32'h14);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // load-use bubble
    cyc(1'b1, I_LW, 32'h20, 1'b1, 1'b0);
    chk("lw.mem_read", o_mr[0], 1);
    chk("lw.wb",       o_wb[0], 1);
    apply(1'b1, I_ADD6, 32'h24, 1'b1, 1'b0);
    chk("lu.ready_stall", o_ready[0], 0);
    tick();
    chk("lu.bubble", o_valid[0], 0);
    apply(1'b1, I_ADD6, 32'h24, 1'b1, 1'b0);
    chk("lu.ready_go", o_ready[0], 1);
    tick();
    chk("lu.issue_valid", o_valid[0], 1);
    chk("lu.issue_pc",    o_pc[0],    32'h24);
    chk("lu.issue_rs1",   o_rs1[0],   5);
    cyc(1'b1, I_LW0, 32'h30, 1'b1, 1'b0);
    apply(1'b1, I_ADD60, 32'h34, 1'b1, 1'b0);
    chk("lwx0.ready", o_ready[0], 1);
    tick();
    chk("lwx0.pc", o_pc[0], 32'h34);

    // stall then flush
    cyc(1'b1, I_SUB, 32'h40, 1'b1, 1'b0);
    chk("sub.alu", o_alu[0], 1);
    apply(1'b1, I_ADDI, 32'h44, 1'b0, 1'b0);
    chk("stall.ready", o_ready[0], 0);
    tick();
    chk("stall.valid", o_valid[0], 1);
    chk("stall.pc",    o_pc[0],    32'h40);
    chk("stall.alu",   o_alu[0],   1);
    apply(1'b1, I_ADDI, 32'h48, 1'b0, 1'b1);
    chk("flush.ready", o_ready[0], 1);
    tick();
    chk("flush.valid", o_valid[0], 0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("flush.dropped", o_valid[0], 0);

    // illegal / M
    cyc(1'b1, I_MUL, 32'h50, 1'b1, 1'b0);
    chk("mul.m0_ill",   o_ill[0],    1);
    chk("mul.m0_rw",    o_rw[0],     0);
    chk("mul.m0_valid", o_valid[0],  1);
    chk("mul.m1_ill",   o_ill[1],    0);
    chk("mul.m1_md",    o_muldiv[1], 1);
    chk("mul.m1_alu",   o_alu[1],    0);
    cyc(1'b1, I_BADSH, 32'h54, 1'b1, 1'b0);
    chk("badsh.ill", o_ill[1], 1);
    cyc(1'b1, 32'hFFFFFFFF, 32'h58, 1'b1, 1'b0);
    chk("badop.ill", o_ill[0], 1);
    chk("badop.rw",  o_rw[0],  0);

    // jumps and other formats
    cyc(1'b1, I_JAL, 32'h100, 1'b1, 1'b0);
    chk("jal.jump", o_jmp[0], 1);
    chk("jal.wb",   o_wb[0],  2);
    chk("jal.opa",  o_opa[0], 1);
    chk("jal.imm",  o_imm[0], 32'hFFFFFFFC);
    cyc(1'b1, I_LUI, 32'h104, 1'b1, 1'b0);
    chk("lui.opa", o_opa[0], 2);
    chk("lui.imm", o_imm[0], 32'h12345000);
    cyc(1'b1, I_SW, 32'h108, 1'b1, 1'b0);
    chk("sw.mw",  o_mw[0],  1);
    chk("sw.rd",  o_rd[0],  0);
    chk("sw.msz", o_msz[0], 2);
    cyc(1'b1, I_BEQ, 32'h10C, 1'b1, 1'b0);
    chk("beq.imm", o_imm[0], 32'hFFFFFFF8);
    cyc(1'b1, I_SRAI, 32'h110, 1'b1, 1'b0);
    chk("srai.alu", o_alu[0], 7);
    chk("srai.imm", o_imm[0], 3);
    cyc(1'b1, I_JALR, 32'h114, 1'b1, 1'b0);
    chk("jalr.opa", o_opa[0], 0);
    chk("jalr.wb",  o_wb[0],  2);
    cyc(1'b1, I_AUIPC, 32'h118, 1'b1, 1'b0);
    chk("auipc.imm", o_imm[0], 32'h1000);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // asynchronous reset while stalled
    cyc(1'b1, I_ADD, 32'h200, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("arst.held", o_valid[0], 1);
    reset = 1'b1;
    #1;
    chk("arst.valid0", o_valid[0], 0);
    chk("arst.valid1", o_valid[1], 0);
    chk("arst.pc",     o_pc[0],    0);
    chk("arst.ready",  o_ready[0], 0);
    tick();
    reset = 1'b0;
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // random mix, checked by the model
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom % 4) != 0, prog[$urandom % 16], $urandom & 32'hFFFFFFFC,
          ($urandom % 4) != 0, ($urandom % 16) == 0);
    end

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RISC-V decode stage that turns a fetched instruction into a complete execute-stage control bundle. It sits between fetch and execute as the ID/EX pipeline register. It generalises the combinational control decode to a parametrised datapath width with optional M-extension decode, a ready/valid handshake on both sides, flush support and automatic load-use bubble insertion.

## Interface
- XLEN, 32: datapath width; 32 or 64 only. Immediates are sign-extended to XLEN.
- ENABLE_M, 0: 1 decodes funct7=0000001 R-type as MUL/DIV; 0 makes those encodings illegal.
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts on in_valid & in_ready.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  kill held and incoming instruction (taken branch/jump).
- ex_ready  in  1  execute accepts the held bundle.
- out_valid  out  1  bundle valid.
- out_pc  out  XLEN  registered in_pc.
- out_rs1, out_rs2, out_rd  out  5 each  register fields; zeroed when unused by the format.
- out_imm  out  XLEN  sign-extended I/S/B/U/J immediate.
- out_alu_op  out  4  0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- out_muldiv  out  1  M op; out_alu_op[2:0] then carries funct3.
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal  out  1 each.
- out_mem_size  out  3  funct3 of load/store.
- out_op_b_reg  out  1  1 = rs2 data, 0 = immediate.
- out_op_a_sel  out  2  00 rs1, 01 pc, 10 zero.
- out_wb_sel  out  2  00 alu, 01 load, 10 pc+4.

## Operation
- Decode covers: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - LUI: op_a zero.
  - AUIPC, BRANCH and JAL: op_a pc.
  - JALR: op_a rs1, jump=1, wb pc+4.
- OP funct7 handling:
  - 0000000: normal ops.
  - 0100000: legal only with funct3 000 (SUB) and 101 (SRA).
  - 0000001: legal only if ENABLE_M.
  - Anything else is illegal.
- OP-IMM shifts:
  - XLEN=32: imm[31:25] must be 0000000, or 0100000 for SRAI; shamt is 5 bits.
  - XLEN=64: imm[31:26] checked the same way; shamt is 6 bits.
- Illegal instruction handling:
  - Covers unknown opcode or a bad funct.
  - Bundle issues with out_valid=1 and out_illegal=1.
  - reg_write, mem_write, mem_read, branch and jump are forced to 0.
- Hazard: asserted when out_valid & out_mem_read & out_rd≠0, and the decoded in_instr actually reads that register as rs1 or rs2.
- in_ready = !reset & (flush | ((!out_valid | ex_ready) & !hazard)).
- Register update, in priority order:
  1. flush: out_valid←0; the input is consumed and dropped.
  2. in_valid & in_ready: load the new bundle, out_valid←1.
  3. hazard & ex_ready: out_valid←0 (one bubble).
  4. ex_ready: out_valid←0.
  5. Otherwise: hold all outputs unchanged.

## Timing
- Latency: 1 cycle from accepted instruction to out_valid.
- Throughput: 1 instruction per cycle without hazards.
- Reset: every output register is 0 (out_valid 0, out_illegal 0), and in_ready is 0 while reset is high.
- Load-use costs exactly one bubble cycle; the dependent instruction issues on the following cycle.
- Stall (out_valid & !ex_ready) holds every out_* stable, in_ready=0.
- Flush during a hazard or stall wins; the next cycle out_valid=0.
- Reset mid-stall drops the held bundle immediately (asynchronous).

## Test plan
- Reset: assert reset with random inputs -> all out_* =0, in_ready=0; release -> in_ready=1.
- Stream: in `add x3,x1,x2` then `addi x4,x3,-1` back-to-back, ex_ready=1 -> consecutive out_valid cycles; alu_op 0/0, out_imm=0xFFFFFFFF (XLEN=32) or all-ones (64), op_b_reg 1/0.
- Load-use: `lw x5,0(x1)` then `add x6,x5,x2` -> one cycle out_valid=0 with in_ready=0, then add issues. `lw x0` followed by a use of x0 -> no bubble.
- Stall/flush: ex_ready=0 for 3 cycles -> outputs stable, in_ready=0; flush in cycle 2 -> next out_valid=0, incoming word dropped.
- Illegal/M: `0x02208033` (mul) with ENABLE_M=0 -> out_illegal=1, reg_write=0; with ENABLE_M=1 -> out_muldiv=1, alu_op[2:0]=000. `0x4000_1013` -> illegal.
- Jumps: JAL at pc 0x100 -> jump=1, wb_sel 10, op_a_sel 01, sign-extended J imm; LUI -> op_a_sel 10.
